// File: rtl/booth_pkg.sv
// Shared widths, data types and FSM encoding for the Booth product accumulator.
package booth_pkg;

  localparam int unsigned N       = 16;
  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned GW      = $clog2(MAX_LEN);
  localparam int unsigned ACC_W   = 2 * N + GW;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);

  typedef logic signed [2*N-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

endpackage

// File: rtl/booth_prod_accum.sv
// Streaming signed accumulator: sums one vector of Booth products per output
// beat and presents the sum, beat count and truncation flag on a registered
// valid/ready port.
module booth_prod_accum #(
  parameter int unsigned N       = booth_pkg::N,
  parameter int unsigned MAX_LEN = booth_pkg::MAX_LEN
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic signed [2*N-1:0]                       prod_i,
  input  logic                                        prod_valid_i,
  input  logic                                        prod_last_i,
  output logic                                        prod_ready_o,
  input  logic                                        abort_i,
  output logic signed [2*N+$clog2(MAX_LEN)-1:0]       sum_o,
  output logic        [$clog2(MAX_LEN+1)-1:0]         count_o,
  output logic                                        trunc_o,
  output logic                                        sum_valid_o,
  input  logic                                        sum_ready_i
);

  import booth_pkg::*;

  localparam int unsigned GW    = $clog2(MAX_LEN);
  localparam int unsigned ACC_W = 2 * N + GW;
  localparam int unsigned CW    = $clog2(MAX_LEN + 1);

  acc_state_t              state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic        [CW-1:0]    cnt, cnt_nxt;

  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] nxt;
  logic        [CW-1:0]    ncnt;
  logic                    accept;
  logic                    at_max;
  logic                    close;
  logic                    xfer;

  // Datapath terms for the beat on the input this cycle.
  always_comb begin
    sx     = {{GW{prod_i[2*N-1]}}, prod_i};
    nxt    = (state == IDLE) ? sx : acc + sx;
    ncnt   = cnt + CW'(1);
    at_max = (ncnt == CW'(MAX_LEN));
    prod_ready_o = ~abort_i & (~sum_valid_o | sum_ready_i);
    accept = prod_valid_i & prod_ready_o;
    close  = accept & (prod_last_i | at_max);
    xfer   = sum_valid_o & sum_ready_i;
  end

  // Next-state logic for the vector FSM, running sum and beat counter.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    if (abort_i) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else if (accept) begin
      if (close) begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ACCUM;
        acc_nxt   = nxt;
        cnt_nxt   = ncnt;
      end
    end
  end

  // Vector FSM, running sum and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output register: loads on a closing beat, drops valid on a bare transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_o       <= '0;
      count_o     <= '0;
      trunc_o     <= 1'b0;
      sum_valid_o <= 1'b0;
    end else if (close) begin
      sum_o       <= nxt;
      count_o     <= ncnt;
      trunc_o     <= ~prod_last_i & at_max;
      sum_valid_o <= 1'b1;
    end else if (xfer) begin
      sum_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
// Scoreboard bench for booth_prod_accum: a reference model pushes expected
// sums when closing beats are accepted; a monitor pops them on each transfer.
module tb_booth_prod_accum;

  localparam int unsigned N     = 16;
  localparam int unsigned ML    = 64;
  localparam int unsigned ACC_W = 38;
  localparam int unsigned CW    = 7;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]    cnt;
    logic             trunc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2*N-1:0]      prod = '0;
  logic                prod_valid = 1'b0;
  logic                prod_last = 1'b0;
  logic                prod_ready;
  logic                abort = 1'b0;
  logic [ACC_W-1:0]    sum;
  logic [CW-1:0]       count;
  logic                trunc;
  logic                sum_valid;
  logic                sum_ready = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  exp_t   sb[$];
  longint m_acc = 0;
  int     m_cnt = 0;

  always #5 clk = ~clk;

  booth_prod_accum #(.N(N), .MAX_LEN(ML)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prod_i       (prod),
    .prod_valid_i (prod_valid),
    .prod_last_i  (prod_last),
    .prod_ready_o (prod_ready),
    .abort_i      (abort),
    .sum_o        (sum),
    .count_o      (count),
    .trunc_o      (trunc),
    .sum_valid_o  (sum_valid),
    .sum_ready_i  (sum_ready)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: called on the edge a beat is accepted.
  task automatic model_beat(input logic [2*N-1:0] v, input logic last);
    exp_t e;
    m_acc += longint'($signed(v));
    m_cnt++;
    if (last || m_cnt == ML) begin
      e.sum   = m_acc[ACC_W-1:0];
      e.cnt   = CW'(m_cnt);
      e.trunc = ~last;
      sb.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [2*N-1:0] v, input logic last);
    int unsigned waits = 0;
    prod = v;
    prod_last = last;
    prod_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (prod_ready) break;
      waits++;
      if (waits > 200) begin
        check_val("beat_accept_timeout", 64'(prod_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    if (prod_ready) model_beat(v, last);
    #1;
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask

  // Monitor: compare each transferred sum against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_sum", 64'(sum_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("sum", 64'(sum), 64'(e.sum));
        check_val("count", 64'(count), 64'(e.cnt));
        check_val("trunc", 64'(trunc), 64'(e.trunc));
      end
    end
  end

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #12;
    @(negedge clk);
    check_val("rst_sum", 64'(sum), 64'd0);
    check_val("rst_valid", 64'(sum_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_count", 64'(count), 64'd0);
    check_val("rst_trunc", 64'(trunc), 64'd0);
    check_val("rst_ready", 64'(prod_ready), 64'd1);

    // Basic three-beat vector with latency check.
    send_beat(32'd15, 1'b0);
    check_val("basic_ready", 64'(prod_ready), 64'd1);
    send_beat(32'hFFFF_FFF2, 1'b0);
    send_beat(32'd100, 1'b1);
    check_val("basic_latency_valid", 64'(sum_valid), 64'd1);
    check_val("basic_sum", 64'(sum), 64'd101);
    drain();

    // Back-to-back single-beat vectors.
    send_beat(32'hC000_0000, 1'b1);
    check_val("single0_sum", 64'(sum), 64'h3F_C000_0000);
    send_beat(32'h4000_0000, 1'b1);
    check_val("single1_sum", 64'(sum), 64'h00_4000_0000);
    check_val("single1_count", 64'(count), 64'd1);
    drain();

    // Truncation at MAX_LEN, then a fresh vector.
    for (int i = 0; i < 64; i++) send_beat(32'h4000_0000, 1'b0);
    check_val("trunc_sum", 64'(sum), 64'h10_0000_0000);
    check_val("trunc_flag", 64'(trunc), 64'd1);
    send_beat(32'h0000_0011, 1'b1);
    check_val("after_trunc_count", 64'(count), 64'd1);
    drain();

    // Backpressure: sum held, input stalled, then simultaneous transfer+accept.
    sum_ready = 1'b0;
    send_beat(32'd7, 1'b0);
    send_beat(32'd8, 1'b1);
    prod = 32'd9;
    prod_last = 1'b1;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_ready", 64'(prod_ready), 64'd0);
      check_val("bp_sum_hold", 64'(sum), 64'd15);
      check_val("bp_valid_hold", 64'(sum_valid), 64'd1);
      @(posedge clk); #1;
    end
    sum_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release_ready", 64'(prod_ready), 64'd1);
    @(posedge clk);
    if (prod_ready) model_beat(32'd9, 1'b1);
    #1;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    check_val("bp_next_sum", 64'(sum), 64'd9);
    check_val("bp_next_valid", 64'(sum_valid), 64'd1);
    drain();

    // Abort discards the partial vector and refuses the beat that cycle.
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    abort = 1'b1;
    prod = 32'd30;
    prod_valid = 1'b1;
    @(negedge clk);
    check_val("abort_ready", 64'(prod_ready), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    prod_valid = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    send_beat(32'd5, 1'b1);
    check_val("abort_sum", 64'(sum), 64'd5);
    drain();

    // Asynchronous reset mid-vector.
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("areset_sum", 64'(sum), 64'd0);
    check_val("areset_count", 64'(count), 64'd0);
    check_val("areset_valid", 64'(sum_valid), 64'd0);
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(32'd3, 1'b1);
    check_val("post_reset_sum", 64'(sum), 64'd3);
    check_val("post_reset_count", 64'(count), 64'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
